// File: rtl/loom_axil_csr_responder_if.sv
// AXI-Lite bus bundle between the loom_shell host master and the CSR responder.
// The master modport drives address/data/ready-for-response; the slave answers.
interface loom_axil_csr_responder_if #(
    parameter int ADDR_WIDTH = 20
);
    logic [ADDR_WIDTH-1:0] araddr;
    logic                  arvalid;
    logic                  arready;
    logic [31:0]           rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic                  awvalid;
    logic                  awready;
    logic [31:0]           wdata;
    logic [3:0]            wstrb;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;

    modport master (
        output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );

    modport slave (
        input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/loom_axil_csr_responder.sv
// AXI-Lite CSR bank (ID, CTRL, IRQ status/mask, scratch) driving the XDMA user IRQ
// and finish flag. One outstanding transaction per channel, all outputs registered.
module loom_axil_csr_responder #(
    parameter int          ADDR_WIDTH = 20,
    parameter int          N_REGS     = 8,
    parameter logic [31:0] ID_VALUE   = 32'h4C4F_4F4D
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    loom_axil_csr_responder_if.slave s_axil,
    input  logic [15:0]             event_i,
    output logic                    irq_o,
    output logic                    finish_o
);
    localparam int IDX_W = ADDR_WIDTH - 2;
    localparam int SEL_W = $clog2(N_REGS);

    typedef enum logic {R_IDLE, R_RESP} r_state_e;

    r_state_e          r_state_q;
    logic              arready_q, rvalid_q;
    logic [31:0]       rdata_q;
    logic [1:0]        rresp_q;
    logic              awready_q, wready_q, aw_held_q, w_held_q, bvalid_q;
    logic [1:0]        bresp_q;
    logic [IDX_W-1:0]  aw_idx_q;
    logic [31:0]       wdata_q;
    logic [3:0]        wstrb_q;
    logic [1:0]        ctrl_q;
    logic [15:0]       status_q, mask_q;
    logic [31:0]       scratch_q [N_REGS];
    logic              irq_q, finish_q;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
        end
        return res;
    endfunction

    logic             aw_hs, w_hs, wr_commit, wr_in_range;
    logic             aw_held_d, w_held_d, bvalid_d;
    logic [IDX_W-1:0] wr_idx, ar_idx;
    logic [SEL_W-1:0] wr_sel, ar_sel;
    logic [31:0]      wr_data, wr_old, wr_merged, rd_word;
    logic [3:0]       wr_strb;
    logic [1:0]       rd_resp;
    logic [15:0]      status_clr;
    logic             unused_addr_lo;

    assign unused_addr_lo = ^{s_axil.araddr[1:0], s_axil.awaddr[1:0]};

    assign aw_hs       = s_axil.awvalid && awready_q;
    assign w_hs        = s_axil.wvalid && wready_q;
    assign wr_commit   = (aw_held_q || aw_hs) && (w_held_q || w_hs);
    assign wr_idx      = aw_held_q ? aw_idx_q : s_axil.awaddr[ADDR_WIDTH-1:2];
    assign wr_data     = w_held_q ? wdata_q : s_axil.wdata;
    assign wr_strb     = w_held_q ? wstrb_q : s_axil.wstrb;
    assign wr_in_range = wr_idx < IDX_W'(N_REGS);
    assign wr_sel      = wr_idx[SEL_W-1:0];
    assign ar_idx      = s_axil.araddr[ADDR_WIDTH-1:2];
    assign ar_sel      = ar_idx[SEL_W-1:0];

    assign aw_held_d = !wr_commit && (aw_held_q || aw_hs);
    assign w_held_d  = !wr_commit && (w_held_q || w_hs);
    assign bvalid_d  = wr_commit || (bvalid_q && !s_axil.bready);

    always_comb begin
        wr_old = scratch_q[wr_sel];
        if (wr_idx == IDX_W'(1)) wr_old = {30'b0, ctrl_q};
        if (wr_idx == IDX_W'(3)) wr_old = {16'b0, mask_q};
    end
    assign wr_merged = merge_bytes(wr_old, wr_data, wr_strb);

    // Write-1-to-clear of IRQ_STATUS; the event OR is applied after, so sets win.
    assign status_clr = (wr_commit && wr_in_range && wr_idx == IDX_W'(2))
                      ? (wr_data[15:0] & {{8{wr_strb[1]}}, {8{wr_strb[0]}}}) : 16'h0;

    always_comb begin
        rd_word = 32'h0;
        rd_resp = 2'b00;
        if (ar_idx >= IDX_W'(N_REGS))  rd_resp = 2'b10;
        else if (ar_idx == IDX_W'(0))  rd_word = ID_VALUE;
        else if (ar_idx == IDX_W'(1))  rd_word = {30'b0, ctrl_q};
        else if (ar_idx == IDX_W'(2))  rd_word = {16'b0, status_q};
        else if (ar_idx == IDX_W'(3))  rd_word = {16'b0, mask_q};
        else                           rd_word = scratch_q[ar_sel];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= 32'h0;
            rresp_q   <= 2'b00;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            aw_idx_q  <= '0;
            wdata_q   <= 32'h0;
            wstrb_q   <= 4'h0;
            ctrl_q    <= 2'b00;
            status_q  <= 16'h0;
            mask_q    <= 16'h0;
            irq_q     <= 1'b0;
            finish_q  <= 1'b0;
            for (int i = 0; i < N_REGS; i++) scratch_q[i] <= 32'h0;
        end else begin
            case (r_state_q)
                R_IDLE: begin
                    arready_q <= 1'b1;
                    if (s_axil.arvalid && arready_q) begin
                        rdata_q   <= rd_word;
                        rresp_q   <= rd_resp;
                        rvalid_q  <= 1'b1;
                        arready_q <= 1'b0;
                        r_state_q <= R_RESP;
                    end
                end
                R_RESP: begin
                    if (s_axil.rready) begin
                        rvalid_q  <= 1'b0;
                        arready_q <= 1'b1;
                        r_state_q <= R_IDLE;
                    end
                end
                default: r_state_q <= R_IDLE;
            endcase

            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            bvalid_q  <= bvalid_d;
            awready_q <= !aw_held_d && !bvalid_d;
            wready_q  <= !w_held_d && !bvalid_d;
            if (aw_hs) aw_idx_q <= s_axil.awaddr[ADDR_WIDTH-1:2];
            if (w_hs) begin
                wdata_q <= s_axil.wdata;
                wstrb_q <= s_axil.wstrb;
            end
            if (wr_commit) bresp_q <= wr_in_range ? 2'b00 : 2'b10;

            if (wr_commit && wr_in_range) begin
                if (wr_idx == IDX_W'(1))      ctrl_q <= wr_merged[1:0];
                else if (wr_idx == IDX_W'(3)) mask_q <= wr_merged[15:0];
                else if (wr_idx >= IDX_W'(4)) scratch_q[wr_sel] <= wr_merged;
            end
            status_q <= (status_q & ~status_clr) | event_i;

            irq_q    <= ctrl_q[1] && |(status_q & mask_q);
            finish_q <= ctrl_q[0];
        end
    end

    assign s_axil.arready = arready_q;
    assign s_axil.rvalid  = rvalid_q;
    assign s_axil.rdata   = rdata_q;
    assign s_axil.rresp   = rresp_q;
    assign s_axil.awready = awready_q;
    assign s_axil.wready  = wready_q;
    assign s_axil.bvalid  = bvalid_q;
    assign s_axil.bresp   = bresp_q;
    assign irq_o          = irq_q;
    assign finish_o       = finish_q;
endmodule

// File: tb/tb_loom_axil_csr_responder.sv
// Directed bench for the CSR responder: a vector table of single transactions
// followed by hand-written sequences for split AW/W, backpressure and IRQ corners.
module tb_loom_axil_csr_responder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] event_v = 16'h0;
    logic        irq, finish;
    int          n_tests = 0;
    int          n_fail = 0;

    loom_axil_csr_responder_if #(.ADDR_WIDTH(20)) axil();

    loom_axil_csr_responder #(.ADDR_WIDTH(20), .N_REGS(8), .ID_VALUE(32'h4C4F_4F4D)) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .s_axil   (axil.slave),
        .event_i  (event_v),
        .irq_o    (irq),
        .finish_o (finish)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        logic [19:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_d;
        logic [1:0]  exp_r;
    } vec_t;

    vec_t vecs[19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic axi_read(input logic [19:0] a, output logic [31:0] d,
                            output logic [1:0] r, output bit ok);
        int n = 0;
        axil.araddr  = a;
        axil.arvalid = 1'b1;
        while (!axil.arready && n < 20) begin step(); n++; end
        step();
        axil.arvalid = 1'b0;
        ok = axil.rvalid && (n < 20);
        d  = axil.rdata;
        r  = axil.rresp;
        axil.rready = 1'b1;
        step();
        axil.rready = 1'b0;
    endtask

    task automatic axi_write(input logic [19:0] a, input logic [31:0] d, input logic [3:0] s,
                             input logic [15:0] ev, output logic [1:0] br, output bit ok);
        int n = 0;
        axil.awaddr  = a;
        axil.awvalid = 1'b1;
        axil.wdata   = d;
        axil.wstrb   = s;
        axil.wvalid  = 1'b1;
        while (!(axil.awready && axil.wready) && n < 20) begin step(); n++; end
        event_v = ev;
        step();
        event_v      = 16'h0;
        axil.awvalid = 1'b0;
        axil.wvalid  = 1'b0;
        ok = axil.bvalid && (n < 20);
        br = axil.bresp;
        axil.bready = 1'b1;
        step();
        axil.bready = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        logic [1:0]  r;
        bit          ok;
        int          bad;

        axil.araddr = '0; axil.arvalid = 1'b0; axil.rready = 1'b0;
        axil.awaddr = '0; axil.awvalid = 1'b0; axil.wdata = '0;
        axil.wstrb = '0;  axil.wvalid = 1'b0;  axil.bready = 1'b0;

        vecs[0]  = '{1'b0, 20'h00000, 32'h0,         4'h0, 32'h4C4F4F4D, 2'b00};
        vecs[1]  = '{1'b0, 20'h00004, 32'h0,         4'h0, 32'h00000000, 2'b00};
        vecs[2]  = '{1'b0, 20'h00008, 32'h0,         4'h0, 32'h00000000, 2'b00};
        vecs[3]  = '{1'b0, 20'h0000C, 32'h0,         4'h0, 32'h00000000, 2'b00};
        vecs[4]  = '{1'b0, 20'h00010, 32'h0,         4'h0, 32'h00000000, 2'b00};
        vecs[5]  = '{1'b0, 20'h0001C, 32'h0,         4'h0, 32'h00000000, 2'b00};
        vecs[6]  = '{1'b1, 20'h00010, 32'hDEADBEEF,  4'h5, 32'h0,        2'b00};
        vecs[7]  = '{1'b0, 20'h00010, 32'h0,         4'h0, 32'h00AD00EF, 2'b00};
        vecs[8]  = '{1'b1, 20'h00000, 32'hFFFFFFFF,  4'hF, 32'h0,        2'b00};
        vecs[9]  = '{1'b0, 20'h00000, 32'h0,         4'h0, 32'h4C4F4F4D, 2'b00};
        vecs[10] = '{1'b0, 20'h00040, 32'h0,         4'h0, 32'h00000000, 2'b10};
        vecs[11] = '{1'b1, 20'h00040, 32'hFFFFFFFF,  4'hF, 32'h0,        2'b10};
        vecs[12] = '{1'b0, 20'h00010, 32'h0,         4'h0, 32'h00AD00EF, 2'b00};
        vecs[13] = '{1'b1, 20'h0001E, 32'hCAFEF00D,  4'hF, 32'h0,        2'b00};
        vecs[14] = '{1'b0, 20'h0001C, 32'h0,         4'h0, 32'hCAFEF00D, 2'b00};
        vecs[15] = '{1'b1, 20'h00004, 32'hFFFFFFFC,  4'hF, 32'h0,        2'b00};
        vecs[16] = '{1'b0, 20'h00004, 32'h0,         4'h0, 32'h00000000, 2'b00};
        vecs[17] = '{1'b1, 20'h0000C, 32'hFFFF1234,  4'hF, 32'h0,        2'b00};
        vecs[18] = '{1'b0, 20'h0000C, 32'h0,         4'h0, 32'h00001234, 2'b00};

        repeat (3) step();
        check("reset_outputs",
              {24'h0, axil.arready, axil.rvalid, axil.awready, axil.wready,
               axil.bvalid, irq, finish, 1'b0},
              32'h0);
        check("reset_rdata_resp", {axil.rdata[29:0], axil.rresp | axil.bresp}, 32'h0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 19; i++) begin
            if (vecs[i].wr) begin
                axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, 16'h0, r, ok);
                check($sformatf("v%0d_bvalid", i), {31'h0, ok}, 32'h1);
                check($sformatf("v%0d_bresp", i), {30'h0, r}, {30'h0, vecs[i].exp_r});
            end else begin
                axi_read(vecs[i].addr, d, r, ok);
                check($sformatf("v%0d_rvalid", i), {31'h0, ok}, 32'h1);
                check($sformatf("v%0d_rdata", i), d, vecs[i].exp_d);
                check($sformatf("v%0d_rresp", i), {30'h0, r}, {30'h0, vecs[i].exp_r});
            end
        end

        // W presented three cycles ahead of AW, then long bready backpressure.
        axil.wdata = 32'h12345678; axil.wstrb = 4'hF; axil.wvalid = 1'b1;
        check("early_w_wready", {31'h0, axil.wready}, 32'h1);
        step();
        axil.wvalid = 1'b0;
        step();
        check("early_w_held", {30'h0, axil.wready, axil.bvalid}, 32'h0);
        step();
        axil.awaddr = 20'h00014; axil.awvalid = 1'b1;
        check("late_aw_awready", {31'h0, axil.awready}, 32'h1);
        step();
        axil.awvalid = 1'b0;
        check("late_aw_bvalid", {31'h0, axil.bvalid}, 32'h1);
        check("late_aw_bresp", {30'h0, axil.bresp}, 32'h0);
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            step();
            if (!axil.bvalid || axil.awready || axil.wready) bad++;
        end
        check("bready_stall", bad, 0);
        axil.bready = 1'b1;
        step();
        axil.bready = 1'b0;
        check("bvalid_drop", {31'h0, axil.bvalid}, 32'h0);
        axi_read(20'h00014, d, r, ok);
        check("split_readback", d, 32'h12345678);

        // IRQ: mask bit 0, enable, pulse events 0 and 1.
        axi_write(20'h0000C, 32'h00000001, 4'hF, 16'h0, r, ok);
        axi_write(20'h00004, 32'h00000002, 4'hF, 16'h0, r, ok);
        event_v = 16'h0003;
        step();
        event_v = 16'h0;
        check("irq_not_yet", {31'h0, irq}, 32'h0);
        step();
        check("irq_set", {31'h0, irq}, 32'h1);
        axi_read(20'h00008, d, r, ok);
        check("status_set", d, 32'h3);
        axi_write(20'h00008, 32'h00000001, 4'hF, 16'h0001, r, ok);
        axi_read(20'h00008, d, r, ok);
        check("status_set_wins", d, 32'h3);
        check("irq_still", {31'h0, irq}, 32'h1);
        axi_write(20'h00008, 32'h00000001, 4'hF, 16'h0, r, ok);
        axi_read(20'h00008, d, r, ok);
        check("status_cleared", d, 32'h2);
        check("irq_cleared", {31'h0, irq}, 32'h0);

        // CTRL finish, then read with rready stalled.
        axi_write(20'h00004, 32'h00000001, 4'hF, 16'h0, r, ok);
        axil.araddr = 20'h00004; axil.arvalid = 1'b1;
        bad = 0;
        while (!axil.arready && bad < 20) begin step(); bad++; end
        step();
        axil.arvalid = 1'b0;
        bad = 0;
        for (int c = 0; c < 4; c++) begin
            if (!axil.rvalid || axil.rdata !== 32'h1 || axil.arready) bad++;
            step();
        end
        check("rready_stall", bad, 0);
        check("finish_o", {31'h0, finish}, 32'h1);
        axil.rready = 1'b1;
        step();
        axil.rready = 1'b0;

        // Reset between AW and W drops the held address.
        axil.awaddr = 20'h00018; axil.awvalid = 1'b1;
        step();
        axil.awvalid = 1'b0;
        rst_n = 1'b0;
        step();
        check("reset_finish", {31'h0, finish}, 32'h0);
        rst_n = 1'b1;
        step();
        axil.wdata = 32'hA5A5A5A5; axil.wstrb = 4'hF; axil.wvalid = 1'b1;
        step();
        axil.wvalid = 1'b0;
        bad = 0;
        for (int c = 0; c < 3; c++) begin
            if (axil.bvalid) bad++;
            step();
        end
        check("reset_drops_aw", bad, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
